// File: rtl/ahb_lite_arbiter.sv
// ============================================================================
// Module   : ahb_lite_arbiter
// Purpose  : Two-master AHB-Lite bus sharer with safe-point handover,
//            lock-timeout flag and per-master saturating transfer counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ahb_lite_arbiter #(
    parameter int DEFAULT_MASTER = 0,
    parameter int LOCK_TIMEOUT   = 256,
    parameter int CNT_W          = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [3:0]           m_htrans,
    input  logic [63:0]          m_haddr,
    input  logic [1:0]           m_hwrite,
    input  logic [5:0]           m_hsize,
    input  logic [5:0]           m_hburst,
    input  logic [1:0]           m_hmastlock,
    input  logic [63:0]          m_hwdata,
    output logic [1:0]           m_hready,
    output logic [1:0]           m_hresp,
    output logic [1:0]           HTRANS,
    output logic [31:0]          HADDR,
    output logic                 HWRITE,
    output logic [2:0]           HSIZE,
    output logic [2:0]           HBURST,
    output logic                 HMASTLOCK,
    output logic [31:0]          HWDATA,
    input  logic                 HREADY,
    input  logic                 HRESP,
    output logic                 owner,
    output logic                 lock_timeout,
    input  logic                 cnt_clr,
    output logic [2*CNT_W-1:0]   xfer_cnt
);

    localparam logic                c_DEFAULT_OWNER = 1'(DEFAULT_MASTER);
    localparam int                  c_WAIT_W        = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST     = c_WAIT_W'(LOCK_TIMEOUT - 1);
    localparam logic [1:0]          c_TRANS_IDLE    = 2'b00;

    logic                r_owner;
    logic                r_d_owner;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_lock_timeout;

    logic [1:0] w_req;
    logic [1:0] w_own_trans;
    logic       w_own_lock;
    logic       w_other_req;
    logic       w_handover;
    logic       w_lock_wait;

    assign w_req       = {m_htrans[3], m_htrans[1]};
    assign w_own_trans = r_owner ? m_htrans[3:2] : m_htrans[1:0];
    assign w_own_lock  = r_owner ? m_hmastlock[1] : m_hmastlock[0];
    assign w_other_req = r_owner ? w_req[0] : w_req[1];

    // Switch only when the owner is truly idle and unlocked, with the bus ready.
    assign w_handover  = HREADY && (w_own_trans == c_TRANS_IDLE) && !w_own_lock && w_other_req;
    assign w_lock_wait = w_own_lock && w_other_req;

    // Address-phase mux follows the owner; write data follows the data-phase owner.
    assign HTRANS    = w_own_trans;
    assign HADDR     = r_owner ? m_haddr[63:32] : m_haddr[31:0];
    assign HWRITE    = r_owner ? m_hwrite[1]    : m_hwrite[0];
    assign HSIZE     = r_owner ? m_hsize[5:3]   : m_hsize[2:0];
    assign HBURST    = r_owner ? m_hburst[5:3]  : m_hburst[2:0];
    assign HMASTLOCK = w_own_lock;
    assign HWDATA    = r_d_owner ? m_hwdata[63:32] : m_hwdata[31:0];

    assign m_hready = r_owner ? {HREADY, 1'b0} : {1'b0, HREADY};
    assign m_hresp  = r_owner ? {HRESP, 1'b0}  : {1'b0, HRESP};

    assign owner        = r_owner;
    assign lock_timeout = r_lock_timeout;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_owner   <= c_DEFAULT_OWNER;
            r_d_owner <= c_DEFAULT_OWNER;
        end else begin
            if (w_handover) begin
                r_owner <= ~r_owner;
            end
            if (HREADY) begin
                r_d_owner <= r_owner;
            end
        end
    end

    // Lock watchdog: flags only, never preempts the locked owner.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wait_cnt     <= '0;
            r_lock_timeout <= 1'b0;
        end else begin
            if (!w_lock_wait) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != c_WAIT_LAST) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            if (cnt_clr) begin
                r_lock_timeout <= 1'b0;
            end else if (r_wait_cnt == c_WAIT_LAST) begin
                r_lock_timeout <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;
        logic             w_inc;

        assign w_inc = HREADY && (r_owner == 1'(gi)) && HTRANS[1];

        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) begin
                r_cnt <= '0;
            end else if (cnt_clr) begin
                r_cnt <= '0;
            end else if (w_inc && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign xfer_cnt[gi*CNT_W +: CNT_W] = r_cnt;
    end

endmodule

`default_nettype wire

// File: tb/tb_ahb_lite_arbiter.sv
// ============================================================================
// Module   : tb_ahb_lite_arbiter
// Purpose  : Directed self-checking bench for ahb_lite_arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ahb_lite_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [3:0]  m_htrans;
    logic [63:0] m_haddr;
    logic [1:0]  m_hwrite;
    logic [5:0]  m_hsize;
    logic [5:0]  m_hburst;
    logic [1:0]  m_hmastlock;
    logic [63:0] m_hwdata;
    logic        HREADY;
    logic        HRESP;
    logic        cnt_clr;

    logic [1:0]  m_hready, m_hresp, HTRANS;
    logic [31:0] HADDR, HWDATA;
    logic        HWRITE, HMASTLOCK, owner, lock_timeout;
    logic [2:0]  HSIZE, HBURST;
    logic [31:0] xfer_cnt;

    logic [1:0]  s_hready, s_hresp, s_htrans;
    logic [31:0] s_haddr, s_hwdata;
    logic        s_hwrite, s_hmastlock, s_owner, s_lock_timeout;
    logic [2:0]  s_hsize, s_hburst;
    logic [7:0]  s_xfer_cnt;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [1:0] c_IDLE   = 2'b00;
    localparam logic [1:0] c_NONSEQ = 2'b10;
    localparam logic [1:0] c_SEQ    = 2'b11;

    always #5 HCLK = ~HCLK;

    ahb_lite_arbiter dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .m_htrans(m_htrans), .m_haddr(m_haddr), .m_hwrite(m_hwrite),
        .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hmastlock(m_hmastlock),
        .m_hwdata(m_hwdata), .m_hready(m_hready), .m_hresp(m_hresp),
        .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .owner(owner),
        .lock_timeout(lock_timeout), .cnt_clr(cnt_clr), .xfer_cnt(xfer_cnt)
    );

    ahb_lite_arbiter #(.CNT_W(4)) dut_s (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .m_htrans(m_htrans), .m_haddr(m_haddr), .m_hwrite(m_hwrite),
        .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hmastlock(m_hmastlock),
        .m_hwdata(m_hwdata), .m_hready(s_hready), .m_hresp(s_hresp),
        .HTRANS(s_htrans), .HADDR(s_haddr), .HWRITE(s_hwrite), .HSIZE(s_hsize),
        .HBURST(s_hburst), .HMASTLOCK(s_hmastlock), .HWDATA(s_hwdata),
        .HREADY(HREADY), .HRESP(HRESP), .owner(s_owner),
        .lock_timeout(s_lock_timeout), .cnt_clr(cnt_clr), .xfer_cnt(s_xfer_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input int m, input logic [1:0] trans, input logic [31:0] addr, input logic lock);
        m_htrans[m*2 +: 2]  = trans;
        m_haddr[m*32 +: 32] = addr;
        m_hmastlock[m]      = lock;
    endtask

    initial begin
        HRESETn     = 1'b0;
        m_htrans    = '0;
        m_haddr     = '0;
        m_hwrite    = 2'b10;
        m_hsize     = {3'd2, 3'd2};
        m_hburst    = '0;
        m_hmastlock = '0;
        m_hwdata    = {32'hB1B1_B1B1, 32'hA0A0_A0A0};
        HREADY      = 1'b1;
        HRESP       = 1'b0;
        cnt_clr     = 1'b0;
        tick();
        tick();
        check("rst_owner", owner, 0);
        check("rst_xfer", xfer_cnt, 0);
        check("rst_lock_to", lock_timeout, 0);
        check("rst_hready", m_hready, 2'b01);
        HRESETn = 1'b1;

        // Single read by m0 while m1 idles
        drive(0, c_NONSEQ, 32'h10, 1'b0);
        #1;
        check("t1_haddr", HADDR, 32'h10);
        check("t1_htrans", HTRANS, c_NONSEQ);
        check("t1_hwrite", HWRITE, 0);
        check("t1_hready", m_hready, 2'b01);
        tick();
        check("t1_xfer0", xfer_cnt[15:0], 1);
        drive(0, c_IDLE, 32'h10, 1'b0);

        // m0 INCR4 burst while m1 waits
        m_hburst = {3'd0, 3'd3};
        drive(1, c_NONSEQ, 32'h200, 1'b0);
        for (int b = 0; b < 4; b++) begin
            drive(0, (b == 0) ? c_NONSEQ : c_SEQ, 32'h100 + 32'(4 * b), 1'b0);
            #1;
            check("t2_stall_m1", m_hready, 2'b01);
            check("t2_haddr", HADDR, 32'h100 + 32'(4 * b));
            if (b == 0) check("t2_hburst", HBURST, 3'd3);
            tick();
        end
        drive(0, c_IDLE, 32'h0, 1'b0);
        m_hburst = '0;
        #1;
        check("t2_owner_hold", owner, 0);
        tick();
        check("t2_owner_switch", owner, 1);
        check("t2_haddr_m1", HADDR, 32'h200);
        check("t2_hready_m1", m_hready, 2'b10);
        check("t2_hwdata_old", HWDATA, 32'hA0A0_A0A0);
        tick();
        check("t2_hwdata_new", HWDATA, 32'hB1B1_B1B1);
        check("t2_xfer0", xfer_cnt[15:0], 5);
        check("t2_xfer1", xfer_cnt[31:16], 1);
        drive(1, c_IDLE, 32'h0, 1'b0);

        // Wait state with m0 idle and m1 pending: no switch until HREADY
        drive(0, c_NONSEQ, 32'h300, 1'b0);
        tick();
        check("t3_owner_back", owner, 0);
        tick();
        drive(0, c_IDLE, 32'h0, 1'b0);
        drive(1, c_NONSEQ, 32'h400, 1'b0);
        HREADY = 1'b0;
        #1;
        check("t3_hwdata_wait", HWDATA, 32'hA0A0_A0A0);
        check("t3_hready_wait", m_hready, 2'b00);
        tick();
        check("t3_owner_wait1", owner, 0);
        tick();
        check("t3_owner_wait2", owner, 0);
        check("t3_hwdata_wait2", HWDATA, 32'hA0A0_A0A0);
        HREADY = 1'b1;
        tick();
        check("t3_owner_switch", owner, 1);
        check("t3_haddr_m1", HADDR, 32'h400);
        tick();
        check("t3_xfer0", xfer_cnt[15:0], 6);
        check("t3_xfer1", xfer_cnt[31:16], 2);
        drive(1, c_IDLE, 32'h0, 1'b0);

        // Locked m0 with m1 pending: lock timeout after 256 cycles
        drive(0, c_NONSEQ, 32'h500, 1'b1);
        tick();
        check("t4_owner_lock", owner, 0);
        drive(1, c_NONSEQ, 32'h600, 1'b0);
        for (int i = 0; i < 256; i++) begin
            drive(0, (i % 2 == 0) ? c_NONSEQ : c_IDLE, 32'h500, 1'b1);
            #1;
            if (i == 0) check("t4_hmastlock", HMASTLOCK, 1);
            tick();
            if (i == 254) check("t4_lock_to_early", lock_timeout, 0);
        end
        check("t4_lock_to_set", lock_timeout, 1);
        check("t4_owner_kept", owner, 0);
        check("t4_xfer0", xfer_cnt[15:0], 134);
        drive(0, c_IDLE, 32'h0, 1'b0);
        drive(1, c_IDLE, 32'h0, 1'b0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("t4_lock_to_clr", lock_timeout, 0);
        check("t4_xfer_clr", xfer_cnt, 0);

        // Error response to m1, then asynchronous reset mid-burst
        drive(1, c_NONSEQ, 32'h700, 1'b0);
        tick();
        check("t5_owner1", owner, 1);
        tick();
        drive(1, c_IDLE, 32'h0, 1'b0);
        HREADY = 1'b0;
        HRESP  = 1'b1;
        #1;
        check("t5_hresp_c1", m_hresp, 2'b10);
        check("t5_hready_c1", m_hready, 2'b00);
        tick();
        HREADY = 1'b1;
        #1;
        check("t5_hresp_c2", m_hresp, 2'b10);
        check("t5_hready_c2", m_hready, 2'b10);
        tick();
        HRESP = 1'b0;
        drive(1, c_NONSEQ, 32'h900, 1'b0);
        tick();
        drive(1, c_SEQ, 32'h904, 1'b0);
        tick();
        check("t5_xfer1_pre", xfer_cnt[31:16], 3);
        check("t5_owner_pre", owner, 1);
        #2;
        HRESETn = 1'b0;
        #1;
        check("t5_rst_owner", owner, 0);
        check("t5_rst_xfer", xfer_cnt, 0);
        check("t5_rst_hready", m_hready, 2'b01);
        drive(1, c_IDLE, 32'h0, 1'b0);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Saturation on the 4-bit-counter instance, then clear beats increment
        drive(0, c_NONSEQ, 32'hA00, 1'b0);
        for (int n = 1; n <= 17; n++) begin
            if (n == 17) cnt_clr = 1'b1;
            tick();
            if (n == 15) check("t6_sat_reach", s_xfer_cnt[3:0], 4'hF);
            if (n == 16) begin
                check("t6_sat_hold", s_xfer_cnt[3:0], 4'hF);
                check("t6_main_16", xfer_cnt[15:0], 16);
            end
        end
        cnt_clr = 1'b0;
        check("t6_clr_small", s_xfer_cnt, 0);
        check("t6_clr_main", xfer_cnt, 0);
        drive(0, c_IDLE, 32'h0, 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
